rename_alloc_ctrl: RTL

- Controller for the 32-entry logical-to-physical map table.
- Allocates physical register tags from a circular free list at rename and drives the map table write port.
- At commit, keeps a committed architectural map and returns superseded tags to the free list.
- On pipeline flush, walks the committed map back into the map table one entry per cycle, then resumes renaming.

---
 rtl/rename_alloc_ctrl_pkg.sv | 14 +
 rtl/rename_free_list.sv | 70 +++++++
 rtl/rename_alloc_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rename_alloc_ctrl_pkg.sv
// rtl/rename_alloc_ctrl_pkg.sv - shared sizes and FSM state type for the rename allocation controller
package rename_alloc_ctrl_pkg;

    localparam int NUM_PREGS = 64;
    localparam int PTAG_W    = $clog2(NUM_PREGS);
    localparam int NUM_LREGS = 32;
    localparam int LREG_W    = 5;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

endpackage

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - circular free list of physical tags with speculative and committed heads
module rename_free_list #(
    parameter int NUM_PREGS = rename_alloc_ctrl_pkg::NUM_PREGS,
    parameter int PTAG_W    = rename_alloc_ctrl_pkg::PTAG_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pop,
    input  logic              i_push,
    input  logic [PTAG_W-1:0] i_push_tag,
    input  logic              i_restore,
    output logic [PTAG_W-1:0] o_head_tag,
    output logic [PTAG_W:0]   o_free_count
);
    import rename_alloc_ctrl_pkg::*;

    // Tags 0..NUM_LREGS-1 start out owned by the identity mapping; the rest are free.
    localparam int              FREE_AT_RESET = NUM_PREGS - NUM_LREGS;
    localparam logic [PTAG_W:0] TAIL_RESET    = (PTAG_W+1)'(FREE_AT_RESET);
    localparam logic [PTAG_W:0] PTR_ONE       = (PTAG_W+1)'(1);

    logic [PTAG_W-1:0] r_slot [NUM_PREGS];
    logic [PTAG_W:0]   r_spec_head;
    logic [PTAG_W:0]   r_commit_head;
    logic [PTAG_W:0]   r_tail;
    logic [PTAG_W:0]   w_commit_head_nxt;
    logic [PTAG_W:0]   w_occupancy;

    // A commit both retires one allocated tag and returns one superseded tag, so
    // commit_head and tail move together.
    assign w_commit_head_nxt = i_push ? (r_commit_head + PTR_ONE) : r_commit_head;
    assign o_head_tag        = r_slot[r_spec_head[PTAG_W-1:0]];
    assign o_free_count      = r_tail - r_spec_head;
    assign w_occupancy       = r_tail - r_commit_head;

    // Slot storage: reset preloads the non-identity tags, commits append at tail.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                r_slot[i] <= (i < FREE_AT_RESET) ? PTAG_W'(i + NUM_LREGS) : '0;
            end
        end else if (i_push) begin
            r_slot[r_tail[PTAG_W-1:0]] <= i_push_tag;
        end
    end

    // Pointer update; a restore rewinds speculation to the post-commit head.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_tail        <= TAIL_RESET;
        end else begin
            r_commit_head <= w_commit_head_nxt;
            if (i_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (i_restore) begin
                r_spec_head <= w_commit_head_nxt;
            end else if (i_pop) begin
                r_spec_head <= r_spec_head + PTR_ONE;
            end
        end
    end

    // More returned tags than the buffer can hold means the commit stream is corrupt.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        int'(w_occupancy) <= NUM_PREGS);

endmodule

// File: rtl/rename_alloc_ctrl.sv
// rtl/rename_alloc_ctrl.sv - rename tag allocation, committed map tracking and flush recovery walk
module rename_alloc_ctrl #(
    parameter int NUM_PREGS = rename_alloc_ctrl_pkg::NUM_PREGS,
    parameter int PTAG_W    = rename_alloc_ctrl_pkg::PTAG_W
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst_n,
    input  logic                                    i_ren_valid,
    input  logic [rename_alloc_ctrl_pkg::LREG_W-1:0] i_ren_rd,
    output logic                                    o_ren_ready,
    output logic [PTAG_W-1:0]                       o_ren_new_preg,
    output logic [PTAG_W-1:0]                       o_ren_old_preg,
    output logic [rename_alloc_ctrl_pkg::LREG_W-1:0] o_map_raddr,
    input  logic [PTAG_W-1:0]                       i_map_rdata,
    output logic                                    o_map_we,
    output logic [rename_alloc_ctrl_pkg::LREG_W-1:0] o_map_waddr,
    output logic [PTAG_W-1:0]                       o_map_wdata,
    input  logic                                    i_cmt_valid,
    input  logic [rename_alloc_ctrl_pkg::LREG_W-1:0] i_cmt_rd,
    input  logic [PTAG_W-1:0]                       i_cmt_new_preg,
    input  logic [PTAG_W-1:0]                       i_cmt_old_preg,
    output logic                                    o_cmt_ready,
    input  logic                                    i_flush,
    output logic                                    o_recovering,
    output logic [PTAG_W:0]                         o_free_count
);
    import rename_alloc_ctrl_pkg::*;

    localparam logic [LREG_W-1:0] LAST_INDEX = LREG_W'(NUM_LREGS - 1);
    localparam logic [LREG_W-1:0] INDEX_ONE  = LREG_W'(1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [LREG_W-1:0] r_index;
    logic [PTAG_W-1:0] r_cmap [NUM_LREGS];
    logic              w_pop;
    logic              w_commit;
    logic [PTAG_W-1:0] w_head_tag;
    logic [PTAG_W:0]   w_free_count;

    // Writes to logical register 0 are architecturally dropped, so they never touch state.
    assign w_commit       = i_cmt_valid & o_cmt_ready & (i_cmt_rd != '0);
    assign o_map_raddr    = i_ren_rd;
    assign o_ren_old_preg = i_map_rdata;
    assign o_free_count   = w_free_count;

    rename_free_list #(
        .NUM_PREGS (NUM_PREGS),
        .PTAG_W    (PTAG_W)
    ) u_free_list (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_pop        (w_pop),
        .i_push       (w_commit),
        .i_push_tag   (i_cmt_old_preg),
        .i_restore    (i_flush),
        .o_head_tag   (w_head_tag),
        .o_free_count (w_free_count)
    );

    // Committed architectural map, identity out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_LREGS; i++) begin
                r_cmap[i] <= PTAG_W'(i);
            end
        end else if (w_commit) begin
            r_cmap[i_cmt_rd] <= i_cmt_new_preg;
        end
    end

    // State register and walk index; any flush restarts the walk from entry 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_flush) begin
                r_index <= '0;
            end else if (r_state == ST_RECOVER) begin
                r_index <= r_index + INDEX_ONE;
            end
        end
    end

    // Next state and handshake/map-port outputs; flush outranks a rename in RUN.
    always_comb begin
        w_state_nxt    = r_state;
        o_ren_ready    = 1'b0;
        o_ren_new_preg = '0;
        o_cmt_ready    = 1'b0;
        o_recovering   = 1'b0;
        o_map_we       = 1'b0;
        o_map_waddr    = '0;
        o_map_wdata    = '0;
        w_pop          = 1'b0;
        case (r_state)
            ST_RUN: begin
                o_cmt_ready = 1'b1;
                if (i_flush) begin
                    w_state_nxt = ST_RECOVER;
                end else begin
                    o_ren_ready = (w_free_count != '0) | (i_ren_rd == '0);
                    if (i_ren_valid & o_ren_ready & (i_ren_rd != '0)) begin
                        w_pop          = 1'b1;
                        o_ren_new_preg = w_head_tag;
                        o_map_we       = 1'b1;
                        o_map_waddr    = i_ren_rd;
                        o_map_wdata    = w_head_tag;
                    end
                end
            end
            ST_RECOVER: begin
                o_recovering = 1'b1;
                o_map_we     = 1'b1;
                o_map_waddr  = r_index;
                o_map_wdata  = r_cmap[r_index];
                if (!i_flush && (r_index == LAST_INDEX)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

endmodule
